usb_crc_engine: RTL and testbench
=================================

Name: usb_crc_engine

Overview:
Parametrised serial CRC engine for the USB packet path; one instance per CRC type (CRC5 for tokens, CRC16 for data). Runs in three modes: accumulate over data bits, serially emit the complemented CRC for TX, and check the received CRC against the residual for RX. It sits between the bit-stuff layer and the packet FSMs and advances only on bit-strobe cycles.

Parameters:
WIDTH, 16, CRC register width (legal range 5..32).
POLY, 16'h8005, generator polynomial without the x^WIDTH term.
INIT, 16'hFFFF, register value loaded on start.
RESIDUAL, 16'h800D, register value after a correct data+CRC stream.
INVERT_OUT, 1, 1 = emit the one's complement of the register MSB during dump.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
start  in  1  pulse: load INIT, enter ACCUM
bit_en  in  1  bit strobe; all shifting occurs only when high
d  in  1  serial data bit, sampled when bit_en=1 in ACCUM
dump  in  1  pulse: begin serial CRC output (legal in ACCUM only)
abort  in  1  return to IDLE immediately
out  out  1  serial CRC bit (valid while out_valid)
out_valid  out  1  high in DUMP
dump_done  out  1  one-cycle pulse after the last CRC bit is shifted
crc_ok  out  1  registered residual match
busy  out  1  state != IDLE
crc_value  out  WIDTH  current register contents

Behaviour:
- Reset, asynchronous on rst_n low: r=INIT, state=IDLE, cnt=0, out_valid=0, dump_done=0, crc_ok=0, busy=0. out is r[WIDTH-1]^INVERT_OUT, so it is 0 when INIT is all ones and INVERT_OUT=1.
- Single clock, rst_n; reset is asynchronous and active-low.
- Step function: fb = r[W-1]^d; r_next = {r[W-2:0],0} ^ (fb ? POLY : 0).
- States and transitions:
  - IDLE: start -> ACCUM with r=INIT. bit_en and dump are ignored.
  - ACCUM: on bit_en, r<=step(r,d) and crc_ok<=(step(r,d)==RESIDUAL). dump -> DUMP, cnt=0, crc_ok<=0.
  - DUMP: out = r[W-1]^INVERT_OUT. On bit_en, r<={r[W-2:0],0} and cnt++. When cnt reaches WIDTH-1 and bit_en=1, the state goes to IDLE and dump_done pulses in the next cycle.
- cnt is $clog2(WIDTH) bits wide. After the dump, r=0 and stays 0 until the next start.
- Priority, highest first: abort > start > dump > bit_en.
  - abort: state=IDLE, crc_ok=0; r is held; no dump_done.
  - start in any state (including DUMP): r=INIT, crc_ok=0, cnt=0; a coincident bit_en is NOT consumed.
  - dump together with bit_en in ACCUM: enter DUMP; the bit is not accumulated and the register does not shift that cycle.
- Illegal requests: dump in IDLE or DUMP is ignored.
- crc_ok:
  - Holds its value across cycles without bit_en.
  - Valid only after the final bit; the consumer samples it at EOP.
  - Cleared by start, dump and abort.
- Latency:
  - crc_ok and crc_value reflect a bit one cycle after its bit_en.
  - out is combinational from r.
  - dump_done is registered.

Test Plan:
- CRC16 defaults, zero-length payload: start, then dump, then 16 bit_en -> out=0 for all 16 bits, out_valid high exactly 16 strobes, dump_done one pulse, busy=0 afterwards.
- CRC16 defaults, RX check: start, then 16 bits of 0 -> crc_value=16'h800D and crc_ok=1. Flip any single bit -> crc_ok=0.
- CRC5 (WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUAL=5'h0C), TX: start, 11 zero bits -> crc_value=5'b10111. Dump emits 0,1,0,0,0.
- CRC5, RX check: start, 11 zeros then 0,1,0,0,0 -> crc_ok=1 and crc_value=5'h0C.
- Simultaneous events:
  - start and bit_en in the same cycle -> crc_value=INIT, bit not consumed.
  - dump and bit_en in ACCUM -> no shift; the first CRC bit is emitted on the next strobe.
- Abort and reset mid-operation:
  - abort after 7 dump bits -> IDLE, no dump_done, crc_ok=0.
  - rst_n asserted between clock edges during ACCUM -> all outputs at reset values immediately.
  - A fresh start after either produces correct CRCs.

Source files
------------

// File: rtl/usb_crc_engine_if.sv
// Handshake/bit-stream bundle between the packet FSMs and usb_crc_engine.
// The engine takes the slave side; the packet FSM (or a bench) takes master.
interface usb_crc_engine_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             bit_en;
    logic             d;
    logic             dump;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic             dump_done;
    logic             crc_ok;
    logic             busy;
    logic [WIDTH-1:0] crc_value;

    modport master (
        output start, bit_en, d, dump, abort,
        input  out, out_valid, dump_done, crc_ok, busy, crc_value
    );

    modport slave (
        input  start, bit_en, d, dump, abort,
        output out, out_valid, dump_done, crc_ok, busy, crc_value
    );
endinterface

// File: rtl/usb_crc_engine.sv
// Serial USB CRC engine: accumulates data bits, dumps the complemented CRC
// MSB first for TX, and flags a residual match for RX. Moves on bit strobes only.
module usb_crc_engine #(
    parameter int             WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(16'h8005),
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(16'hFFFF),
    parameter logic [WIDTH-1:0] RESIDUAL = WIDTH'(16'h800D),
    parameter bit             INVERT_OUT = 1'b1
) (
    input logic clk,
    input logic rst_n,
    usb_crc_engine_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] r_step;

    // One serial CRC step: shift left, fold in the polynomial on feedback.
    function automatic logic [WIDTH-1:0] crc_step(
        input logic [WIDTH-1:0] r,
        input logic             din
    );
        logic fb;
        fb = r[WIDTH-1] ^ din;
        return {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // Next register value if the current data bit were accumulated.
    always_comb r_step = crc_step(r_q, bus.d);

    // Next-state logic; abort beats start beats dump beats the bit strobe.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            ok_d    = 1'b0;
        end else if (bus.start) begin
            state_d = ACCUM;
            r_d     = INIT;
            cnt_d   = '0;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (bus.dump) begin
                        state_d = DUMP;
                        cnt_d   = '0;
                        ok_d    = 1'b0;
                    end else if (bus.bit_en) begin
                        r_d  = r_step;
                        ok_d = (r_step == RESIDUAL);
                    end
                end
                DUMP: begin
                    if (bus.bit_en) begin
                        r_d   = {r_q[WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, CRC register, dump counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= INIT;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
        end
    end

    // Outputs; the serial bit is combinational from the register MSB.
    always_comb begin
        bus.out       = r_q[WIDTH-1] ^ INVERT_OUT;
        bus.out_valid = (state_q == DUMP);
        bus.busy      = (state_q != IDLE);
        bus.dump_done = done_q;
        bus.crc_ok    = ok_q;
        bus.crc_value = r_q;
    end
endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: a CRC5 vector table plus CRC16
// sequences for dump, RX check, abort and asynchronous reset.
module tb_usb_crc_engine;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    usb_crc_engine_if #(.WIDTH(16)) if16 ();
    usb_crc_engine_if #(.WIDTH(5))  if5 ();

    usb_crc_engine #(
        .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF),
        .RESIDUAL(16'h800D), .INVERT_OUT(1'b1)
    ) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    usb_crc_engine #(
        .WIDTH(5), .POLY(5'h05), .INIT(5'h1F),
        .RESIDUAL(5'h0C), .INVERT_OUT(1'b1)
    ) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, be, d, dm, ab;
        logic [4:0] crc;
        logic       o, ov, dd, ok, bz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic st, be, d, dm, ab,
        input logic [4:0] crc,
        input logic o, ov, dd, ok, bz
    );
        vec_t v;
        v.st = st; v.be = be; v.d = d; v.dm = dm; v.ab = ab;
        v.crc = crc; v.o = o; v.ov = ov; v.dd = dd; v.ok = ok; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv16(input logic st, be, d, dm, ab);
        if16.start = st; if16.bit_en = be; if16.d = d;
        if16.dump = dm; if16.abort = ab;
    endtask

    task automatic drv5(input logic st, be, d, dm, ab);
        if5.start = st; if5.bit_en = be; if5.d = d;
        if5.dump = dm; if5.abort = ab;
    endtask

    task automatic chk16_idle(input string nm, input logic [15:0] crc);
        chk({nm, ".crc"}, 32'(if16.crc_value), 32'(crc));
        chk({nm, ".busy"}, 32'(if16.busy), 32'd0);
        chk({nm, ".ov"}, 32'(if16.out_valid), 32'd0);
        chk({nm, ".ok"}, 32'(if16.crc_ok), 32'd0);
        chk({nm, ".dd"}, 32'(if16.dump_done), 32'd0);
    endtask

    // Start then 16 zero bits: residual must appear with crc_ok set.
    task automatic rx16_zero(input string nm);
        drv16(1, 0, 0, 0, 0); tick();
        for (int j = 0; j < 16; j++) begin
            drv16(0, 1, 0, 0, 0); tick();
        end
        drv16(0, 0, 0, 0, 0);
        chk({nm, ".crc"}, 32'(if16.crc_value), 32'h800D);
        chk({nm, ".ok"}, 32'(if16.crc_ok), 32'd1);
    endtask

    initial begin
        int nov;
        int ndd;
        logic [4:0] zs[11];
        logic [4:0] tail[5];
        n_checks = 0;
        n_err    = 0;
        drv16(0, 0, 0, 0, 0);
        drv5(0, 0, 0, 0, 0);

        // CRC5 table: hand-stepped register values, out = ~MSB
        zs = '{5'h1B, 5'h13, 5'h03, 5'h06, 5'h0C, 5'h18,
               5'h15, 5'h0F, 5'h1E, 5'h19, 5'h17};
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'h1F, 0, 0, 0, 0, 1));
        for (int i = 0; i < 11; i++)
            tbl.push_back(mk(0, 1, 0, 0, 0, zs[i], ~zs[i][4], 0, 0,
                             zs[i] == 5'h0C, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 5'h17, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'h0E, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'h1C, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'h18, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'h10, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'h00, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 5'h1F, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 5'h1E, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'h1E, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'h1E, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 5'h1E, 0, 0, 0, 0, 0));

        // reset state
        rst_n = 1'b0;
        #12;
        chk16_idle("rst16", 16'hFFFF);
        chk("rst16.out", 32'(if16.out), 32'd0);
        chk("rst5.crc", 32'(if5.crc_value), 32'h1F);
        chk("rst5.busy", 32'(if5.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // CRC5 vector table
        foreach (tbl[i]) begin
            drv5(tbl[i].st, tbl[i].be, tbl[i].d, tbl[i].dm, tbl[i].ab);
            tick();
            chk($sformatf("t5[%0d].crc", i), 32'(if5.crc_value), 32'(tbl[i].crc));
            chk($sformatf("t5[%0d].out", i), 32'(if5.out), 32'(tbl[i].o));
            chk($sformatf("t5[%0d].ov", i), 32'(if5.out_valid), 32'(tbl[i].ov));
            chk($sformatf("t5[%0d].dd", i), 32'(if5.dump_done), 32'(tbl[i].dd));
            chk($sformatf("t5[%0d].ok", i), 32'(if5.crc_ok), 32'(tbl[i].ok));
            chk($sformatf("t5[%0d].busy", i), 32'(if5.busy), 32'(tbl[i].bz));
        end
        drv5(0, 0, 0, 0, 0);

        // CRC5 RX: 11 zeros then the CRC bits 0,1,0,0,0
        tail = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drv5(1, 0, 0, 0, 0); tick();
        for (int j = 0; j < 11; j++) begin
            drv5(0, 1, 0, 0, 0); tick();
        end
        for (int j = 0; j < 5; j++) begin
            drv5(0, 1, tail[j][0], 0, 0); tick();
        end
        drv5(0, 0, 0, 0, 0);
        chk("rx5.crc", 32'(if5.crc_value), 32'h0C);
        chk("rx5.ok", 32'(if5.crc_ok), 32'd1);
        tick();
        chk("rx5.ok_hold", 32'(if5.crc_ok), 32'd1);
        drv5(0, 0, 0, 1, 0); tick();
        drv5(0, 0, 0, 0, 0);
        chk("rx5.ok_dump_clr", 32'(if5.crc_ok), 32'd0);
        drv5(0, 0, 0, 0, 1); tick();
        drv5(0, 0, 0, 0, 0);

        // CRC16 zero-length payload dump
        drv16(1, 0, 0, 0, 0); tick();
        drv16(0, 0, 0, 1, 0); tick();
        chk("tx16.crc_held", 32'(if16.crc_value), 32'hFFFF);
        nov = 0;
        ndd = 0;
        for (int j = 0; j < 16; j++) begin
            if (if16.out_valid) nov++;
            chk($sformatf("tx16.out[%0d]", j), 32'(if16.out), 32'd0);
            drv16(0, 1, 0, 0, 0); tick();
            if (if16.dump_done) ndd++;
        end
        chk("tx16.ov_strobes", 32'(nov), 32'd16);
        for (int j = 0; j < 4; j++) begin
            drv16(0, 1, 0, 0, 0); tick();
            if (if16.dump_done) ndd++;
        end
        drv16(0, 0, 0, 0, 0);
        chk("tx16.dd_pulses", 32'(ndd), 32'd1);
        chk16_idle("tx16.after", 16'h0000);

        // CRC16 RX: zeros give residual; any single flip clears crc_ok
        rx16_zero("rx16");
        tick();
        chk("rx16.ok_hold", 32'(if16.crc_ok), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drv16(1, 0, 0, 0, 0); tick();
            for (int j = 0; j < 16; j++) begin
                drv16(0, 1, j == i, 0, 0); tick();
            end
            drv16(0, 0, 0, 0, 0);
            chk($sformatf("rx16.flip%0d.ok", i), 32'(if16.crc_ok), 32'd0);
        end

        // abort after 7 dump bits
        drv16(1, 0, 0, 0, 0); tick();
        drv16(0, 0, 0, 1, 0); tick();
        for (int j = 0; j < 7; j++) begin
            drv16(0, 1, 0, 0, 0); tick();
        end
        chk("ab16.ov_before", 32'(if16.out_valid), 32'd1);
        chk("ab16.crc_before", 32'(if16.crc_value), 32'hFF80);
        drv16(0, 0, 0, 0, 1); tick();
        drv16(0, 0, 0, 0, 0);
        chk16_idle("ab16", 16'hFF80);
        ndd = 0;
        for (int j = 0; j < 12; j++) begin
            drv16(0, 1, 0, 0, 0); tick();
            if (if16.dump_done) ndd++;
        end
        drv16(0, 0, 0, 0, 0);
        chk("ab16.no_dd", 32'(ndd), 32'd0);
        rx16_zero("ab16.fresh");

        // asynchronous reset between edges during ACCUM
        drv16(1, 0, 0, 0, 0); tick();
        for (int j = 0; j < 5; j++) begin
            drv16(0, 1, 1, 0, 0); tick();
        end
        drv16(0, 0, 0, 0, 0);
        chk("ar16.busy_before", 32'(if16.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk16_idle("ar16", 16'hFFFF);
        chk("ar16.out", 32'(if16.out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rx16_zero("ar16.fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
